// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall controller: FSM states, the action
// encoding and a helper that expands an action into per-register controls.
package stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        FLUSH_PEND,
        FETCH_DISCARD
    } stall_state_t;

    typedef enum logic [2:0] {
        ACT_RUN,
        ACT_FLUSH,
        ACT_DSTALL,
        ACT_DHSTALL,
        ACT_ISTALL
    } stall_act_t;

    typedef struct packed {
        logic pc_wr;
        logic if_id_wr;
        logic id_exe_wr;
        logic exe_mem_wr;
        logic mem_mem2_wr;
        logic mem2_wb_wr;
        logic if_id_flush;
        logic id_exe_flush;
        logic exe_mem_flush;
        logic mem_mem2_flush;
        logic mem2_wb_flush;
        logic pc_redirect;
    } pipe_ctrl_t;

    // Control word applied while the pipeline simply advances.
    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_wr: 1'b1, if_id_wr: 1'b1, id_exe_wr: 1'b1, exe_mem_wr: 1'b1,
        mem_mem2_wr: 1'b1, mem2_wb_wr: 1'b1,
        if_id_flush: 1'b0, id_exe_flush: 1'b0, exe_mem_flush: 1'b0,
        mem_mem2_flush: 1'b0, mem2_wb_flush: 1'b0,
        pc_redirect: 1'b0
    };

    // Control word forced while the core is held in reset.
    localparam pipe_ctrl_t CTRL_RESET = '{
        pc_wr: 1'b0, if_id_wr: 1'b0, id_exe_wr: 1'b0, exe_mem_wr: 1'b0,
        mem_mem2_wr: 1'b0, mem2_wb_wr: 1'b0,
        if_id_flush: 1'b1, id_exe_flush: 1'b1, exe_mem_flush: 1'b1,
        mem_mem2_flush: 1'b1, mem2_wb_flush: 1'b1,
        pc_redirect: 1'b0
    };

    // Expands a single action into the enables and flushes of every register.
    function automatic pipe_ctrl_t act_ctrl(input stall_act_t act);
        pipe_ctrl_t c;
        c = CTRL_RUN;
        case (act)
            ACT_FLUSH: begin
                c.pc_redirect    = 1'b1;
                c.if_id_flush    = 1'b1;
                c.id_exe_flush   = 1'b1;
                c.exe_mem_flush  = 1'b1;
                c.mem_mem2_flush = 1'b1;
            end
            ACT_DSTALL: begin
                c.pc_wr         = 1'b0;
                c.if_id_wr      = 1'b0;
                c.id_exe_wr     = 1'b0;
                c.exe_mem_wr    = 1'b0;
                c.mem_mem2_wr   = 1'b0;
                c.mem2_wb_flush = 1'b1;
            end
            ACT_DHSTALL: begin
                c.pc_wr        = 1'b0;
                c.if_id_wr     = 1'b0;
                c.id_exe_flush = 1'b1;
            end
            ACT_ISTALL: begin
                c.pc_wr       = 1'b0;
                c.if_id_flush = 1'b1;
            end
            default: c = CTRL_RUN;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear first, otherwise step unless already all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: picks one action per cycle from hazard,
// cache and exception inputs, tracks deferred flushes and discarded fetches,
// and counts stall cycles.
module pipeline_stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ID_EX_DH_Stall,
    input  logic             ID_MEM1_DH_Stall,
    input  logic             ID_MEM2_DH_Stall,
    input  logic             ICache_Busy,
    input  logic             DCache_Busy,
    input  logic             MEM_Exception,
    input  logic             Perf_Clear,
    output logic             PC_Wr,
    output logic             IF_ID_Wr,
    output logic             ID_EXE_Wr,
    output logic             EXE_MEM_Wr,
    output logic             MEM_MEM2_Wr,
    output logic             MEM2_WB_Wr,
    output logic             IF_ID_Flush,
    output logic             ID_EXE_Flush,
    output logic             EXE_MEM_Flush,
    output logic             MEM_MEM2_Flush,
    output logic             MEM2_WB_Flush,
    output logic             PC_Redirect,
    output logic [CNT_W-1:0] DH_StallCnt,
    output logic [CNT_W-1:0] Cache_StallCnt
);

    stall_state_t state_q;
    stall_state_t state_d;
    stall_act_t   act;
    pipe_ctrl_t   ctrl;
    logic         dh;
    logic         backDstall;
    logic         dhInc;
    logic         cacheInc;

    assign dh = ID_EX_DH_Stall | ID_MEM1_DH_Stall | ID_MEM2_DH_Stall;

    // State register; reset abandons any pending flush or fetch discard.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Action selection, next state and counter increment requests.
    always_comb begin
        state_d    = state_q;
        act        = ACT_RUN;
        backDstall = 1'b0;
        dhInc      = 1'b0;
        cacheInc   = 1'b0;
        case (state_q)
            RUN: begin
                if (MEM_Exception && DCache_Busy) begin
                    act      = ACT_DSTALL;
                    cacheInc = 1'b1;
                    state_d  = FLUSH_PEND;
                end else if (MEM_Exception) begin
                    act     = ACT_FLUSH;
                    state_d = ICache_Busy ? FETCH_DISCARD : RUN;
                end else if (DCache_Busy) begin
                    act      = ACT_DSTALL;
                    cacheInc = 1'b1;
                end else if (dh) begin
                    act   = ACT_DHSTALL;
                    dhInc = 1'b1;
                end else if (ICache_Busy) begin
                    act      = ACT_ISTALL;
                    cacheInc = 1'b1;
                end
            end
            FLUSH_PEND: begin
                if (DCache_Busy) begin
                    act      = ACT_DSTALL;
                    cacheInc = 1'b1;
                end else begin
                    act     = ACT_FLUSH;
                    state_d = ICache_Busy ? FETCH_DISCARD : RUN;
                end
            end
            FETCH_DISCARD: begin
                act        = ACT_ISTALL;
                backDstall = DCache_Busy;
                cacheInc   = ICache_Busy | DCache_Busy;
                if (!ICache_Busy) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Expand the action; back-stage D-cache stall overlays a fetch discard.
    always_comb begin
        ctrl = act_ctrl(act);
        if (backDstall) begin
            ctrl.id_exe_wr     = 1'b0;
            ctrl.exe_mem_wr    = 1'b0;
            ctrl.mem_mem2_wr   = 1'b0;
            ctrl.mem2_wb_flush = 1'b1;
        end
        if (!resetn) begin
            ctrl = CTRL_RESET;
        end
    end

    assign PC_Wr          = ctrl.pc_wr;
    assign IF_ID_Wr       = ctrl.if_id_wr;
    assign ID_EXE_Wr      = ctrl.id_exe_wr;
    assign EXE_MEM_Wr     = ctrl.exe_mem_wr;
    assign MEM_MEM2_Wr    = ctrl.mem_mem2_wr;
    assign MEM2_WB_Wr     = ctrl.mem2_wb_wr;
    assign IF_ID_Flush    = ctrl.if_id_flush;
    assign ID_EXE_Flush   = ctrl.id_exe_flush;
    assign EXE_MEM_Flush  = ctrl.exe_mem_flush;
    assign MEM_MEM2_Flush = ctrl.mem_mem2_flush;
    assign MEM2_WB_Flush  = ctrl.mem2_wb_flush;
    assign PC_Redirect    = ctrl.pc_redirect;

    sat_counter #(.W(CNT_W)) u_dh_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (dhInc),
        .clr    (Perf_Clear),
        .cnt    (DH_StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_cache_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (cacheInc),
        .clr    (Perf_Clear),
        .cnt    (Cache_StallCnt)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed scenarios plus a
// randomized run, all checked against a flag-based behavioural model.
module tb_pipeline_stall_ctrl;

    logic clk;
    logic resetn;
    logic dh1, dh2, dh3, iBusy, dBusy, exc, pclr;

    logic        PC_Wr, IF_ID_Wr, ID_EXE_Wr, EXE_MEM_Wr, MEM_MEM2_Wr, MEM2_WB_Wr;
    logic        IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, MEM_MEM2_Flush, MEM2_WB_Flush;
    logic        PC_Redirect;
    logic [31:0] dhCnt, cacheCnt;

    logic        sPC_Wr, sIF_ID_Wr, sID_EXE_Wr, sEXE_MEM_Wr, sMEM_MEM2_Wr, sMEM2_WB_Wr;
    logic        sIF_ID_Flush, sID_EXE_Flush, sEXE_MEM_Flush, sMEM_MEM2_Flush, sMEM2_WB_Flush;
    logic        sPC_Redirect;
    logic [2:0]  sDhCnt, sCacheCnt;

    int total = 0;
    int bad   = 0;

    // Output order: {PC,IF_ID,ID_EXE,EXE_MEM,MEM_MEM2,MEM2_WB Wr, IF_ID..MEM2_WB Flush, Redirect}
    logic [11:0] outVec;
    assign outVec = {PC_Wr, IF_ID_Wr, ID_EXE_Wr, EXE_MEM_Wr, MEM_MEM2_Wr, MEM2_WB_Wr,
                     IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, MEM_MEM2_Flush,
                     MEM2_WB_Flush, PC_Redirect};

    pipeline_stall_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .ID_EX_DH_Stall(dh1), .ID_MEM1_DH_Stall(dh2), .ID_MEM2_DH_Stall(dh3),
        .ICache_Busy(iBusy), .DCache_Busy(dBusy), .MEM_Exception(exc), .Perf_Clear(pclr),
        .PC_Wr(PC_Wr), .IF_ID_Wr(IF_ID_Wr), .ID_EXE_Wr(ID_EXE_Wr), .EXE_MEM_Wr(EXE_MEM_Wr),
        .MEM_MEM2_Wr(MEM_MEM2_Wr), .MEM2_WB_Wr(MEM2_WB_Wr),
        .IF_ID_Flush(IF_ID_Flush), .ID_EXE_Flush(ID_EXE_Flush), .EXE_MEM_Flush(EXE_MEM_Flush),
        .MEM_MEM2_Flush(MEM_MEM2_Flush), .MEM2_WB_Flush(MEM2_WB_Flush),
        .PC_Redirect(PC_Redirect), .DH_StallCnt(dhCnt), .Cache_StallCnt(cacheCnt)
    );

    // Narrow-counter instance so saturation is reachable in a short run.
    pipeline_stall_ctrl #(.CNT_W(3)) dutSmall (
        .clk(clk), .resetn(resetn),
        .ID_EX_DH_Stall(dh1), .ID_MEM1_DH_Stall(dh2), .ID_MEM2_DH_Stall(dh3),
        .ICache_Busy(iBusy), .DCache_Busy(dBusy), .MEM_Exception(exc), .Perf_Clear(pclr),
        .PC_Wr(sPC_Wr), .IF_ID_Wr(sIF_ID_Wr), .ID_EXE_Wr(sID_EXE_Wr), .EXE_MEM_Wr(sEXE_MEM_Wr),
        .MEM_MEM2_Wr(sMEM_MEM2_Wr), .MEM2_WB_Wr(sMEM2_WB_Wr),
        .IF_ID_Flush(sIF_ID_Flush), .ID_EXE_Flush(sID_EXE_Flush), .EXE_MEM_Flush(sEXE_MEM_Flush),
        .MEM_MEM2_Flush(sMEM_MEM2_Flush), .MEM2_WB_Flush(sMEM2_WB_Flush),
        .PC_Redirect(sPC_Redirect), .DH_StallCnt(sDhCnt), .Cache_StallCnt(sCacheCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          excPend, discarding;
    bit          nextPend, nextDisc, incDh, incCache;
    longint      mDh, mCache, mSmallDh, mSmallCache;
    logic [11:0] expOut;

    // Compute expected outputs for the current inputs and the model's flags.
    task automatic modelPredict();
        logic [5:0] wr;
        logic [4:0] fl;
        logic       rd;
        bit         anyDh;
        wr = 6'b111111; fl = 5'b00000; rd = 1'b0;
        incDh = 0; incCache = 0;
        anyDh = dh1 | dh2 | dh3;
        if (!resetn) begin
            excPend = 0; discarding = 0;
            mDh = 0; mCache = 0; mSmallDh = 0; mSmallCache = 0;
            nextPend = 0; nextDisc = 0;
            wr = 6'b000000; fl = 5'b11111;
        end else begin
            nextPend = excPend; nextDisc = discarding;
            if (discarding) begin
                wr[5] = 0; fl[4] = 1;
                if (dBusy) begin wr[3:1] = 3'b000; fl[0] = 1; end
                incCache = iBusy | dBusy;
                nextDisc = iBusy;
            end else if (excPend && dBusy) begin
                wr[5:1] = 5'b00000; fl[0] = 1; incCache = 1;
            end else if (excPend) begin
                rd = 1; fl[4:1] = 4'b1111; nextPend = 0; nextDisc = iBusy;
            end else if (exc && dBusy) begin
                wr[5:1] = 5'b00000; fl[0] = 1; incCache = 1; nextPend = 1;
            end else if (exc) begin
                rd = 1; fl[4:1] = 4'b1111; nextDisc = iBusy;
            end else if (dBusy) begin
                wr[5:1] = 5'b00000; fl[0] = 1; incCache = 1;
            end else if (anyDh) begin
                wr[5] = 0; wr[4] = 0; fl[3] = 1; incDh = 1;
            end else if (iBusy) begin
                wr[5] = 0; fl[4] = 1; incCache = 1;
            end
        end
        expOut = {wr, fl, rd};
    endtask

    // Commit the model at the rising edge.
    task automatic modelAdvance();
        if (resetn) begin
            excPend = nextPend; discarding = nextDisc;
            if (pclr) begin
                mDh = 0; mCache = 0; mSmallDh = 0; mSmallCache = 0;
            end else begin
                if (incDh) begin
                    mDh      = (mDh == 64'hFFFFFFFF) ? mDh : mDh + 1;
                    mSmallDh = (mSmallDh == 7) ? 7 : mSmallDh + 1;
                end
                if (incCache) begin
                    mCache      = (mCache == 64'hFFFFFFFF) ? mCache : mCache + 1;
                    mSmallCache = (mSmallCache == 7) ? 7 : mSmallCache + 1;
                end
            end
        end
    endtask

    // Drive inputs (called at a falling edge), then settle and predict.
    task automatic applyStimulus(input logic d1, input logic d2, input logic d3,
                                 input logic ib, input logic db, input logic ex,
                                 input logic cl);
        dh1 = d1; dh2 = d2; dh3 = d3; iBusy = ib; dBusy = db; exc = ex; pclr = cl;
        #1;
        modelPredict();
    endtask

    // Cross the rising edge and return to the next falling edge.
    task automatic stepClock();
        @(posedge clk);
        modelAdvance();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0;
        @(negedge clk);
        applyStimulus(0, 0, 0, 1, 1, 1, 0);
        total++;
        if (outVec !== 12'b000000_11111_0) begin
            bad++; $display("[TB] FAIL reset_ctrl got=%b want=%b", outVec, 12'b000000_11111_0);
        end
        total++;
        if (dhCnt !== 32'd0 || cacheCnt !== 32'd0) begin
            bad++; $display("[TB] FAIL reset_cnt got=%0d/%0d want=0/0", dhCnt, cacheCnt);
        end
        stepClock();
        resetn = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (outVec !== 12'b111111_00000_0) begin
            bad++; $display("[TB] FAIL reset_release got=%b want=%b", outVec, 12'b111111_00000_0);
        end
        stepClock();
    endtask

    task automatic test_dh_stall();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, 0, 1, 0, 0, 0);
            total++;
            if (outVec !== expOut || PC_Wr !== 1'b0 || IF_ID_Wr !== 1'b0 ||
                IF_ID_Flush !== 1'b0 || ID_EXE_Flush !== 1'b1) begin
                bad++; $display("[TB] FAIL dh_stall[%0d] got=%b want=%b", i, outVec, expOut);
            end
            stepClock();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (dhCnt !== 32'd2 || cacheCnt !== 32'd0) begin
            bad++; $display("[TB] FAIL dh_counts got=%0d/%0d want=2/0", dhCnt, cacheCnt);
        end
        stepClock();
    endtask

    task automatic test_dcache_stall();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        stepClock();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0);
            total++;
            if (outVec !== expOut || outVec !== 12'b000001_00001_0) begin
                bad++; $display("[TB] FAIL dcache_stall[%0d] got=%b want=%b", i, outVec, expOut);
            end
            stepClock();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (cacheCnt !== 32'd3 || dhCnt !== 32'd0) begin
            bad++; $display("[TB] FAIL dcache_counts got=%0d/%0d want=0/3", dhCnt, cacheCnt);
        end
        stepClock();
    endtask

    task automatic test_exc_dcache();
        int redirects = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, 0, (i < 4), (i == 0), 0);
            total++;
            if (outVec !== expOut) begin
                bad++; $display("[TB] FAIL exc_dcache[%0d] got=%b want=%b", i, outVec, expOut);
            end
            if (PC_Redirect === 1'b1) redirects++;
            total++;
            if (PC_Redirect !== (i == 4)) begin
                bad++; $display("[TB] FAIL exc_dcache_redirect[%0d] got=%b want=%b", i, PC_Redirect, (i == 4));
            end
            stepClock();
        end
        total++;
        if (redirects != 1) begin
            bad++; $display("[TB] FAIL exc_dcache_once got=%0d want=1", redirects);
        end
    endtask

    task automatic test_exc_icache();
        applyStimulus(0, 0, 0, 1, 0, 1, 0);
        total++;
        if (outVec !== expOut || outVec !== 12'b111111_11110_1) begin
            bad++; $display("[TB] FAIL exc_icache_flush got=%b want=%b", outVec, expOut);
        end
        stepClock();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, (i < 3), 0, 0, 0);
            total++;
            if (outVec !== expOut || PC_Wr !== 1'b0 || IF_ID_Flush !== 1'b1) begin
                bad++; $display("[TB] FAIL exc_icache_discard[%0d] got=%b want=%b", i, outVec, expOut);
            end
            stepClock();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (PC_Wr !== 1'b1 || outVec !== 12'b111111_00000_0) begin
            bad++; $display("[TB] FAIL exc_icache_resume got=%b want=%b", outVec, 12'b111111_00000_0);
        end
        stepClock();
    endtask

    task automatic test_saturation();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        stepClock();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0);
            stepClock();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (sCacheCnt !== 3'd5) begin
            bad++; $display("[TB] FAIL sat_preload got=%0d want=5", sCacheCnt);
        end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 0, 0);
            stepClock();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (sCacheCnt !== 3'd7 || sCacheCnt !== 3'(mSmallCache)) begin
            bad++; $display("[TB] FAIL sat_hold got=%0d want=7", sCacheCnt);
        end
        total++;
        if (cacheCnt !== 32'd10) begin
            bad++; $display("[TB] FAIL sat_wide got=%0d want=10", cacheCnt);
        end
        stepClock();
    endtask

    task automatic test_perf_clear();
        applyStimulus(1, 0, 0, 0, 1, 0, 1);
        stepClock();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (cacheCnt !== 32'd0 || sCacheCnt !== 3'd0 || dhCnt !== 32'd0) begin
            bad++; $display("[TB] FAIL perf_clear got=%0d/%0d/%0d want=0/0/0", dhCnt, cacheCnt, sCacheCnt);
        end
        stepClock();
    endtask

    task automatic test_reset_in_discard();
        applyStimulus(0, 0, 0, 1, 0, 1, 0);
        stepClock();
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        stepClock();
        resetn = 1'b0;
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        total++;
        if (outVec !== 12'b000000_11111_0 || outVec !== expOut) begin
            bad++; $display("[TB] FAIL reset_discard got=%b want=%b", outVec, 12'b000000_11111_0);
        end
        stepClock();
        resetn = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (outVec !== 12'b111111_00000_0) begin
            bad++; $display("[TB] FAIL reset_discard_run got=%b want=%b", outVec, 12'b111111_00000_0);
        end
        stepClock();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic d1, d2, d3, ib, db, ex, cl;
            d1 = ($urandom_range(0, 9) == 0);
            d2 = ($urandom_range(0, 9) == 0);
            d3 = ($urandom_range(0, 9) == 0);
            ib = ($urandom_range(0, 3) == 0);
            db = ($urandom_range(0, 3) == 0);
            ex = ($urandom_range(0, 11) == 0);
            cl = ($urandom_range(0, 49) == 0);
            // Hazards and exceptions cannot arise while a fetch is discarded.
            if (discarding) begin
                d1 = 0; d2 = 0; d3 = 0; ex = 0;
            end
            applyStimulus(d1, d2, d3, ib, db, ex, cl);
            total++;
            if (outVec !== expOut) begin
                bad++; $display("[TB] FAIL rand_ctrl[%0d] got=%b want=%b", i, outVec, expOut);
            end
            total++;
            if (dhCnt !== 32'(mDh) || cacheCnt !== 32'(mCache) ||
                sDhCnt !== 3'(mSmallDh) || sCacheCnt !== 3'(mSmallCache)) begin
                bad++; $display("[TB] FAIL rand_cnt[%0d] got=%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d",
                                i, dhCnt, cacheCnt, sDhCnt, sCacheCnt, mDh, mCache, mSmallDh, mSmallCache);
            end
            stepClock();
        end
    endtask

    initial begin
        resetn = 1'b0;
        dh1 = 0; dh2 = 0; dh3 = 0; iBusy = 0; dBusy = 0; exc = 0; pclr = 0;
        excPend = 0; discarding = 0;
        mDh = 0; mCache = 0; mSmallDh = 0; mSmallCache = 0;
        test_reset();
        test_dh_stall();
        test_dcache_stall();
        test_exc_dcache();
        test_exc_icache();
        test_saturation();
        test_perf_clear();
        test_reset_in_discard();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
